prio_enc_arb: RTL and testbench
===============================

# prio_enc_arb

Parametrised, registered priority encoder with an optional round-robin mode and a valid/ready handshake on both sides. It is the next generation of the team's 8-to-3 one-hot encoder. It accepts an N-bit request vector, selects one set bit under fixed (MSB-first) or rotating priority, and registers the winning index, its one-hot grant and a multi-request flag into a single-entry output stage. Zero vectors are counted and flagged rather than producing an undefined code.

## Interface
- N, 8, request width; legal range 2..256
- W, $clog2(N), index width; derived, not overridden
- RR, 0, 0 = fixed priority; 1 = round-robin priority
- CNTW, 8, width of the zero-request drop counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req  in  N  request vector; bit b maps to index i = N-1-b (MSB is index 0)
- in_valid  in  1  req is valid this cycle
- in_ready  out  1  block can accept req this cycle
- out_valid  out  1  output register holds a result
- out_ready  in  1  downstream consumes the result this cycle
- out_idx  out  W  winning index
- out_onehot  out  N  winning bit, in req bit positions
- out_multi  out  1  more than one req bit was set in the accepted vector
- err_zero  out  1  one-cycle pulse: an all-zero vector was accepted
- drop_cnt  out  CNTW  saturating count of accepted all-zero vectors

## Operation
- in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready.
- Fixed mode (RR=0): the lowest set index wins. 8'b10000000 -> 0; 8'b00000001 -> 7.
- Round-robin mode (RR=1): an internal pointer ptr (W bits) marks the highest-priority index. The block searches indices ptr, ptr+1, …, N-1, 0, …, ptr-1, and the first set index wins.
- After an accepted non-zero vector with winner k: ptr <= (k+1) mod N. The wrap from N-1 goes to 0. For non-power-of-2 N, the wrap is at N, not 2^W.
- ptr is unchanged on zero vectors, on idle cycles and in fixed mode.
- Accept of a non-zero vector: out_valid <= 1. out_idx, out_onehot and out_multi are loaded from the same cycle's req and ptr.
- Accept of a zero vector:
  - out_valid <= 0; the old result is consumed because in_ready implied out_ready or !out_valid.
  - err_zero <= 1 for one cycle.
  - drop_cnt increments and saturates at 2^CNTW-1.
- No accept and out_ready && out_valid: out_valid <= 0. Data outputs hold their last value.
- out_valid && !out_ready: all outputs hold. The upstream vector is not sampled.
- err_zero is 0 in every cycle without a zero-vector accept.

## Timing
- Reset (asynchronous, any time, including mid-transfer) clears immediately:
  - out_valid = 0, out_idx = 0, out_onehot = 0, out_multi = 0
  - err_zero = 0, drop_cnt = 0, ptr = 0
  - in_ready = 1 while out_valid = 0
- Release is synchronous to clk. The first accept can occur on the first rising edge with rst_n high.
- Latency is 1 cycle: a vector accepted at edge t is visible on the outputs after edge t.
- Throughput is 1 result per cycle while out_ready stays high. No bubble on simultaneous consume and accept: the old result leaves and the new one loads on the same edge.
- Backpressure: while out_valid=1 and out_ready=0, in_ready=0 and every output is stable. A result is never lost or duplicated.
- Sequential state is out_valid, the output data, err_zero, drop_cnt and ptr. No combinational path from req to any output.

## Test plan
- Reset, then fixed priority, N=8, RR=0, out_ready=1:
  - assert rst_n=0 mid-stream -> all outputs 0 and in_ready=1 immediately
  - req = 8'b10000000, then 8'b00010000, then 8'b00000001 -> out_idx 0, 3, 7 on consecutive cycles; out_onehot equals req; out_multi=0
- Multi-request, fixed mode: req = 8'b01000101 -> out_idx=1, out_onehot=8'b01000000, out_multi=1.
- Round-robin, RR=1: req=8'hFF for 10 accepts -> out_idx sequence 0,1,2,3,4,5,6,7,0,1. Then req=8'b00100001 with ptr=2 -> idx 2, then idx 7, then idx 2.
- Backpressure: hold out_ready=0 for 5 cycles after an accept -> out_valid=1, outputs constant, in_ready=0, ptr unchanged. Raise out_ready with a new vector present -> that vector is loaded on the same edge.
- Zero vectors, CNTW=8: accept req=0 with out_valid=1 and out_ready=1 -> out_valid=0, err_zero high exactly 1 cycle, drop_cnt=1. After 300 zero accepts -> drop_cnt=255.
- Non-power-of-2, N=5, RR=1: req=5'b11111 for 6 accepts -> out_idx 0,1,2,3,4,0; ptr never reaches 5..7.

Source files
------------

// File: rtl/prio_enc_arb.sv
// prio_enc_arb: registered N-bit priority encoder with fixed (MSB-first)
// or round-robin priority and a single-entry output stage.
//
// Index convention: req bit b corresponds to index i = N-1-b, so the MSB is
// index 0. The winner is reported as an index (out_idx) and as a one-hot
// vector in the original req bit positions (out_onehot).
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The input side has in_ready = !out_valid || out_ready, so a new
// vector may load on the same edge the old result is consumed. Once
// out_valid is high, the result and all data outputs stay stable until
// out_ready is seen high.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req          N-bit request vector
//   in_valid     req is valid this cycle
//   in_ready     block can accept req this cycle
//   out_valid    output register holds a result
//   out_ready    downstream consumes the result this cycle
//   out_idx      winning index
//   out_onehot   winning bit in req bit positions
//   out_multi    more than one req bit was set in the accepted vector
//   err_zero     one-cycle pulse after an all-zero vector is accepted
//   drop_cnt     saturating count of accepted all-zero vectors
module prio_enc_arb #(
    parameter int N    = 8,
    parameter int RR   = 0,
    parameter int CNTW = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N-1:0]            req,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(N)-1:0]    out_idx,
    output logic [N-1:0]            out_onehot,
    output logic                    out_multi,
    output logic                    err_zero,
    output logic [CNTW-1:0]         drop_cnt
);

    localparam int W = $clog2(N);

    // Registered state and next-state values.
    logic            out_valid_q,  out_valid_d;
    logic [W-1:0]    out_idx_q,    out_idx_d;
    logic [N-1:0]    out_onehot_q, out_onehot_d;
    logic            out_multi_q,  out_multi_d;
    logic            err_zero_q,   err_zero_d;
    logic [CNTW-1:0] drop_cnt_q,   drop_cnt_d;
    logic [W-1:0]    ptr_q,        ptr_d;

    // Combinational search results.
    logic [N-1:0]    req_by_idx;
    logic            found_c;
    logic [W-1:0]    win_idx_c;
    logic [N-1:0]    onehot_c;
    logic            multi_c;
    logic [W-1:0]    ptr_nxt_c;
    logic            accept;
    int              base;
    int              cand;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Reorder req so that position i holds the request for index i.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_by_idx[i] = req[N-1-i];
        end
    end

    // Circular search starting at base; fixed mode always starts at 0, which
    // makes "lowest set index wins" the same loop as round-robin.
    always_comb begin
        found_c   = 1'b0;
        win_idx_c = '0;
        cand      = 0;
        base      = (RR != 0) ? int'(ptr_q) : 0;
        for (int off = 0; off < N; off++) begin
            cand = base + off;
            // Wrap at N (not 2^W) so non-power-of-2 widths stay in range.
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!found_c && req_by_idx[W'(cand)]) begin
                found_c   = 1'b1;
                win_idx_c = W'(cand);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            onehot_c[N-1-i] = found_c && (win_idx_c == W'(i));
        end
    end

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_c   = |(req & (req - N'(1)));
    assign ptr_nxt_c = (win_idx_c == W'(N-1)) ? '0 : win_idx_c + W'(1);

    always_comb begin
        out_valid_d  = out_valid_q;
        out_idx_d    = out_idx_q;
        out_onehot_d = out_onehot_q;
        out_multi_d  = out_multi_q;
        err_zero_d   = 1'b0;
        drop_cnt_d   = drop_cnt_q;
        ptr_d        = ptr_q;
        if (accept) begin
            if (found_c) begin
                out_valid_d  = 1'b1;
                out_idx_d    = win_idx_c;
                out_onehot_d = onehot_c;
                out_multi_d  = multi_c;
                if (RR != 0) begin
                    ptr_d = ptr_nxt_c;
                end
            end else begin
                // The previous result (if any) is consumed by this same edge,
                // since accepting implies out_ready or an empty stage.
                out_valid_d = 1'b0;
                err_zero_d  = 1'b1;
                if (drop_cnt_q != '1) begin
                    drop_cnt_d = drop_cnt_q + CNTW'(1);
                end
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_idx_q    <= '0;
            out_onehot_q <= '0;
            out_multi_q  <= 1'b0;
            err_zero_q   <= 1'b0;
            drop_cnt_q   <= '0;
            ptr_q        <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_idx_q    <= out_idx_d;
            out_onehot_q <= out_onehot_d;
            out_multi_q  <= out_multi_d;
            err_zero_q   <= err_zero_d;
            drop_cnt_q   <= drop_cnt_d;
            ptr_q        <= ptr_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_idx    = out_idx_q;
    assign out_onehot = out_onehot_q;
    assign out_multi  = out_multi_q;
    assign err_zero   = err_zero_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_prio_enc_arb.sv
// Directed testbench for prio_enc_arb: three instances share one clock
// (N=8 fixed, N=8 round-robin, N=5 round-robin).
module tb_prio_enc_arb;

    logic clk;
    logic rst_n;

    // Fixed priority, N=8
    logic [7:0] req_f;
    logic       iv_f, ir_f, ov_f, or_f, multi_f, ez_f;
    logic [2:0] idx_f;
    logic [7:0] oh_f, dc_f;

    // Round-robin, N=8
    logic [7:0] req_r;
    logic       iv_r, ir_r, ov_r, or_r, multi_r, ez_r;
    logic [2:0] idx_r;
    logic [7:0] oh_r, dc_r;

    // Round-robin, N=5
    logic [4:0] req_n;
    logic       iv_n, ir_n, ov_n, or_n, multi_n, ez_n;
    logic [2:0] idx_n;
    logic [4:0] oh_n;
    logic [7:0] dc_n;

    int n_checks;
    int n_errors;
    logic [31:0] exp_q[$];

    prio_enc_arb #(.N(8), .RR(0), .CNTW(8)) u_fix (
        .clk(clk), .rst_n(rst_n), .req(req_f), .in_valid(iv_f), .in_ready(ir_f),
        .out_valid(ov_f), .out_ready(or_f), .out_idx(idx_f), .out_onehot(oh_f),
        .out_multi(multi_f), .err_zero(ez_f), .drop_cnt(dc_f)
    );

    prio_enc_arb #(.N(8), .RR(1), .CNTW(8)) u_rr (
        .clk(clk), .rst_n(rst_n), .req(req_r), .in_valid(iv_r), .in_ready(ir_r),
        .out_valid(ov_r), .out_ready(or_r), .out_idx(idx_r), .out_onehot(oh_r),
        .out_multi(multi_r), .err_zero(ez_r), .drop_cnt(dc_r)
    );

    prio_enc_arb #(.N(5), .RR(1), .CNTW(8)) u_np (
        .clk(clk), .rst_n(rst_n), .req(req_n), .in_valid(iv_n), .in_ready(ir_n),
        .out_valid(ov_n), .out_ready(or_n), .out_idx(idx_n), .out_onehot(oh_n),
        .out_multi(multi_n), .err_zero(ez_n), .drop_cnt(dc_n)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: inputs already driven; sample 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] e;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        req_f = '0; iv_f = 1'b0; or_f = 1'b1;
        req_r = '0; iv_r = 1'b0; or_r = 1'b1;
        req_n = '0; iv_n = 1'b0; or_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        check_eq("rst_ov", 32'(ov_f), 32'd0);
        check_eq("rst_ir", 32'(ir_f), 32'd1);
        check_eq("rst_dc", 32'(dc_f), 32'd0);

        // ---- Fixed priority ----
        iv_f = 1'b1; req_f = 8'b1000_0000;
        step();
        check_eq("fix_ov0", 32'(ov_f), 32'd1);
        check_eq("fix_idx0", 32'(idx_f), 32'd0);
        check_eq("fix_oh0", 32'(oh_f), 32'h80);
        check_eq("fix_multi0", 32'(multi_f), 32'd0);
        req_f = 8'b0001_0000;
        step();
        check_eq("fix_idx3", 32'(idx_f), 32'd3);
        check_eq("fix_oh3", 32'(oh_f), 32'h10);
        check_eq("fix_ir", 32'(ir_f), 32'd1);
        req_f = 8'b0000_0001;
        step();
        check_eq("fix_idx7", 32'(idx_f), 32'd7);
        check_eq("fix_oh7", 32'(oh_f), 32'h01);
        req_f = 8'b0100_0101;
        step();
        check_eq("fix_multi_idx", 32'(idx_f), 32'd1);
        check_eq("fix_multi_oh", 32'(oh_f), 32'h40);
        check_eq("fix_multi", 32'(multi_f), 32'd1);

        // ---- Zero vector with a result present and out_ready high ----
        req_f = 8'h00;
        step();
        check_eq("zero_ov", 32'(ov_f), 32'd0);
        check_eq("zero_ez", 32'(ez_f), 32'd1);
        check_eq("zero_dc", 32'(dc_f), 32'd1);
        check_eq("zero_idx_hold", 32'(idx_f), 32'd1);
        iv_f = 1'b0;
        step();
        check_eq("zero_ez_pulse", 32'(ez_f), 32'd0);
        check_eq("zero_dc_hold", 32'(dc_f), 32'd1);

        // ---- Asynchronous reset mid-stream ----
        iv_f = 1'b1; req_f = 8'b0000_0100;
        step();
        check_eq("pre_rst_ov", 32'(ov_f), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("arst_ov", 32'(ov_f), 32'd0);
        check_eq("arst_idx", 32'(idx_f), 32'd0);
        check_eq("arst_oh", 32'(oh_f), 32'd0);
        check_eq("arst_multi", 32'(multi_f), 32'd0);
        check_eq("arst_ez", 32'(ez_f), 32'd0);
        check_eq("arst_dc", 32'(dc_f), 32'd0);
        check_eq("arst_ir", 32'(ir_f), 32'd1);
        iv_f = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // ---- Drop counter saturation ----
        iv_f = 1'b1; req_f = 8'h00;
        for (int i = 0; i < 300; i++) begin
            step();
            if (i == 0) check_eq("sat_dc1", 32'(dc_f), 32'd1);
            if (i == 254) check_eq("sat_dc255", 32'(dc_f), 32'd255);
        end
        check_eq("sat_dc_final", 32'(dc_f), 32'd255);
        iv_f = 1'b0;
        step();
        check_eq("sat_ez_low", 32'(ez_f), 32'd0);

        // ---- Round-robin, N=8 ----
        check_eq("rr_ptr_init", 32'(u_rr.ptr_q), 32'd0);
        for (int i = 0; i < 10; i++) exp_q.push_back(32'(i % 8));
        iv_r = 1'b1; req_r = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            step();
            e = exp_q.pop_front();
            check_eq("rr_ff_idx", 32'(idx_r), e);
            check_eq("rr_ff_oh", 32'(oh_r), 32'h80 >> e);
        end
        check_eq("rr_ptr2", 32'(u_rr.ptr_q), 32'd2);

        exp_q.push_back(32'd2); exp_q.push_back(32'd7); exp_q.push_back(32'd2);
        req_r = 8'b0010_0001;
        for (int i = 0; i < 3; i++) begin
            step();
            e = exp_q.pop_front();
            check_eq("rr_pair_idx", 32'(idx_r), e);
            check_eq("rr_pair_multi", 32'(multi_r), 32'd1);
        end
        check_eq("rr_ptr3", 32'(u_rr.ptr_q), 32'd3);

        // ---- Backpressure ----
        or_r = 1'b0; req_r = 8'b0000_0100;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("bp_ov", 32'(ov_r), 32'd1);
            check_eq("bp_idx", 32'(idx_r), 32'd2);
            check_eq("bp_oh", 32'(oh_r), 32'h20);
            check_eq("bp_ir", 32'(ir_r), 32'd0);
            check_eq("bp_ptr", 32'(u_rr.ptr_q), 32'd3);
        end
        or_r = 1'b1;
        #1;
        check_eq("bp_release_ir", 32'(ir_r), 32'd1);
        step();
        check_eq("bp_load_idx", 32'(idx_r), 32'd5);
        check_eq("bp_load_oh", 32'(oh_r), 32'h04);
        check_eq("bp_load_multi", 32'(multi_r), 32'd0);
        check_eq("bp_ptr6", 32'(u_rr.ptr_q), 32'd6);
        req_r = 8'h00;
        step();
        check_eq("rr_zero_ptr", 32'(u_rr.ptr_q), 32'd6);
        check_eq("rr_zero_ez", 32'(ez_r), 32'd1);
        iv_r = 1'b0;

        // ---- Round-robin, N=5 ----
        exp_q.push_back(32'd0); exp_q.push_back(32'd1); exp_q.push_back(32'd2);
        exp_q.push_back(32'd3); exp_q.push_back(32'd4); exp_q.push_back(32'd0);
        iv_n = 1'b1; req_n = 5'b11111;
        for (int i = 0; i < 6; i++) begin
            step();
            e = exp_q.pop_front();
            check_eq("np_idx", 32'(idx_n), e);
            check_eq("np_oh", 32'(oh_n), 32'h10 >> e);
            check_eq("np_ptr", 32'(u_np.ptr_q), (e + 1) % 5);
        end
        iv_n = 1'b0;
        step();
        check_eq("np_drain_ov", 32'(ov_n), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
